// File: rtl/gpio_input_filter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : gpio_input_filter                                             |
// | Purpose  : Per-pin synchronizer, stable-count debounce, edge detect and  |
// |            sticky edge flags with a single registered interrupt request. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module gpio_input_filter #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pin_raw,
    input  logic [DATA_WIDTH-1:0] en_rise,
    input  logic [DATA_WIDTH-1:0] en_fall,
    input  logic [DATA_WIDTH-1:0] flag_clr,
    output logic [DATA_WIDTH-1:0] pin_clean,
    output logic [DATA_WIDTH-1:0] rise,
    output logic [DATA_WIDTH-1:0] fall,
    output logic [DATA_WIDTH-1:0] flags,
    output logic                  irq
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] r_sync1;
    logic [DATA_WIDTH-1:0] r_sync2;
    logic [DATA_WIDTH-1:0] w_accept;
    logic [DATA_WIDTH-1:0] w_rise_next;
    logic [DATA_WIDTH-1:0] w_fall_next;
    logic [DATA_WIDTH-1:0] w_flags_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Each pin runs its own stable-sample counter; a new level is accepted
    // on the DEBOUNCE_CYCLES-th consecutive differing sample.
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 w_diff;

        assign w_diff      = r_sync2[i] ^ pin_clean[i];
        assign w_accept[i] = w_diff && (r_cnt == c_CNT_MAX);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_cnt <= '0;
            end else if (!w_diff || w_accept[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Set takes priority over a simultaneous clear so no edge is lost.
    assign w_rise_next  = w_accept & r_sync2;
    assign w_fall_next  = w_accept & ~r_sync2;
    assign w_flags_next = (w_rise_next & en_rise) | (w_fall_next & en_fall)
                        | (flags & ~flag_clr);

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_clean <= '0;
            rise      <= '0;
            fall      <= '0;
            flags     <= '0;
            irq       <= 1'b0;
        end else begin
            pin_clean <= pin_clean ^ w_accept;
            rise      <= w_rise_next;
            fall      <= w_fall_next;
            flags     <= w_flags_next;
            irq       <= |w_flags_next;
        end
    end

endmodule
`default_nettype wire
